// File: rtl/axi_wt_pkg.sv
// rtl/axi_wt_pkg.sv - shared types and constants for the write-through burst master
//
// Purpose : FSM state encoding, AXI response codes and the fixed AW attribute
//           values used by axi_mem_burst_wt.
// Ports   : none (package)
package axi_wt_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      XFER   = 2'd1,
      WAIT_B = 2'd2
   } wt_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [2:0] SIZE_WORD   = 3'b010;

endpackage

// File: rtl/axi_wt_beat_cnt.sv
// rtl/axi_wt_beat_cnt.sv - loadable beat down-counter with last-beat flag
//
// Purpose : holds the number of W beats still owed for the current burst.
// Ports   : ACLK, ARESETn  clock / asynchronous active-low reset
//           i_load         load i_load_val (wins over i_dec)
//           i_load_val     beat count to load
//           i_dec          one beat accepted this cycle
//           o_nonzero      beats remain
//           o_last         exactly one beat remains
module axi_wt_beat_cnt #(
   parameter int LW = 5
) (
   input  logic          ACLK,
   input  logic          ARESETn,
   input  logic          i_load,
   input  logic [LW-1:0] i_load_val,
   input  logic          i_dec,
   output logic          o_nonzero,
   output logic          o_last
);

   logic [LW-1:0] r_count;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - LW'(1);
      end
   end

   assign o_nonzero = (r_count != '0);
   assign o_last    = (r_count == LW'(1));

endmodule

// File: rtl/axi_mem_burst_wt.sv
// rtl/axi_mem_burst_wt.sv - single-outstanding AXI4 write-burst master
//
// Purpose : accepts a word-addressed burst request, issues one INCR AW with
//           word-size beats, passes the beat stream straight onto W, and
//           reports the B response as a one-cycle done pulse. Bad lengths
//           complete immediately with SLVERR and no bus traffic.
// Config  : AXI4_ADDR_WIDTH, AXI4_DATA_WIDTH, AXI4_ID_WIDTH, AXI4_USER_WIDTH,
//           MAX_BURST, WT_ID. Define AXI_WT_4K_CHECK_EN to also reject bursts
//           whose byte range crosses a 4 KB boundary.
// Ports   : ACLK, ARESETn                       clock / async active-low reset
//           AW*  / W*  / B*                     AXI4 write master channels
//           wt_req_i, wt_word_addr_i, wt_len_i  burst request (held until gnt)
//           wt_gnt_o                            request accepted pulse
//           wt_dvalid_i, wt_data_i, wt_strb_i,
//           wt_dready_o                         beat stream in
//           wt_done_o, wt_resp_o                completion pulse and response
module axi_mem_burst_wt
   import axi_wt_pkg::*;
#(
   parameter int AXI4_ADDR_WIDTH = 32,
   parameter int AXI4_DATA_WIDTH = 32,
   parameter int AXI4_ID_WIDTH   = 16,
   parameter int AXI4_USER_WIDTH = 10,
   parameter int MAX_BURST       = 16,
   parameter int WT_ID           = 0,
   localparam int SW             = AXI4_DATA_WIDTH / 8,
   localparam int LW             = $clog2(MAX_BURST + 1)
) (
   input  logic                       ACLK,
   input  logic                       ARESETn,

   output logic [AXI4_ID_WIDTH-1:0]   AWID,
   output logic [AXI4_ADDR_WIDTH-1:0] AWADDR,
   output logic [7:0]                 AWLEN,
   output logic [2:0]                 AWSIZE,
   output logic [1:0]                 AWBURST,
   output logic                       AWLOCK,
   output logic [3:0]                 AWCACHE,
   output logic [2:0]                 AWPROT,
   output logic [3:0]                 AWREGION,
   output logic [AXI4_USER_WIDTH-1:0] AWUSER,
   output logic [3:0]                 AWQOS,
   output logic                       AWVALID,
   input  logic                       AWREADY,

   output logic [AXI4_DATA_WIDTH-1:0] WDATA,
   output logic [SW-1:0]              WSTRB,
   output logic                       WLAST,
   output logic [AXI4_USER_WIDTH-1:0] WUSER,
   output logic                       WVALID,
   input  logic                       WREADY,

   input  logic [AXI4_ID_WIDTH-1:0]   BID,
   input  logic [1:0]                 BRESP,
   input  logic [AXI4_USER_WIDTH-1:0] BUSER,
   input  logic                       BVALID,
   output logic                       BREADY,

   input  logic                       wt_req_i,
   input  logic [AXI4_ADDR_WIDTH-3:0] wt_word_addr_i,
   input  logic [LW-1:0]              wt_len_i,
   output logic                       wt_gnt_o,

   input  logic                       wt_dvalid_i,
   input  logic [AXI4_DATA_WIDTH-1:0] wt_data_i,
   input  logic [SW-1:0]              wt_strb_i,
   output logic                       wt_dready_o,

   output logic                       wt_done_o,
   output logic [1:0]                 wt_resp_o
);

   wt_state_e                  r_state;
   wt_state_e                  w_state_nxt;
   logic [AXI4_ADDR_WIDTH-3:0] r_addr;
   logic [LW-1:0]              r_len;
   logic                       r_aw_done;
   logic                       r_gnt;
   logic                       r_done;
   logic [1:0]                 r_resp;

   logic          w_len_ok;
   logic          w_cross;
   logic          w_accept;
   logic          w_reject;
   logic          w_b_hs;
   logic          w_aw_hs;
   logic          w_w_hs;
   logic          w_nonzero;
   logic          w_last;
   logic [LW-1:0] w_len_m1;
   logic          w_unused;

   assign w_unused = ^BUSER;

`ifdef AXI_WT_4K_CHECK_EN
   // 1024 words per 4 KB page: crossing when page offset + len exceeds it.
   assign w_cross = ({2'b00, wt_word_addr_i[9:0]} + 12'(wt_len_i)) > 12'd1024;
`else
   assign w_cross = 1'b0;
`endif

   assign w_len_ok = (wt_len_i != '0) && (wt_len_i <= LW'(MAX_BURST)) && !w_cross;

   // ---------------- beat counter ----------------
   axi_wt_beat_cnt #(.LW(LW)) u_beat_cnt (
      .ACLK       (ACLK),
      .ARESETn    (ARESETn),
      .i_load     (w_accept),
      .i_load_val (wt_len_i),
      .i_dec      (w_w_hs),
      .o_nonzero  (w_nonzero),
      .o_last     (w_last)
   );

   // ---------------- AW channel ----------------
   assign w_len_m1 = r_len - LW'(1);
   assign AWID     = AXI4_ID_WIDTH'(WT_ID);
   assign AWADDR   = {r_addr, 2'b00};
   assign AWLEN    = 8'(w_len_m1);
   assign AWSIZE   = SIZE_WORD;
   assign AWBURST  = BURST_INCR;
   assign AWLOCK   = 1'b0;
   assign AWCACHE  = '0;
   assign AWPROT   = '0;
   assign AWREGION = '0;
   assign AWUSER   = '0;
   assign AWQOS    = '0;
   assign AWVALID  = (r_state == XFER) && !r_aw_done;
   assign w_aw_hs  = AWVALID && AWREADY;

   // ---------------- W channel (pass-through) ----------------
   assign WVALID      = wt_dvalid_i && w_nonzero;
   assign wt_dready_o = WREADY && w_nonzero;
   assign WDATA       = wt_data_i;
   assign WSTRB       = wt_strb_i;
   assign WLAST       = w_last;
   assign WUSER       = '0;
   assign w_w_hs      = WVALID && WREADY;

   // ---------------- B channel ----------------
   assign BREADY = (r_state == WAIT_B);

   assign wt_gnt_o  = r_gnt;
   assign wt_done_o = r_done;
   assign wt_resp_o = r_resp;

   // ---------------- FSM ----------------
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_reject    = 1'b0;
      w_b_hs      = 1'b0;
      case (r_state)
         IDLE: begin
            // Blocking on r_gnt/r_done keeps a still-held request from being
            // taken twice and keeps grants out of the done cycle.
            if (wt_req_i && !r_gnt && !r_done) begin
               if (w_len_ok) begin
                  w_accept    = 1'b1;
                  w_state_nxt = XFER;
               end else begin
                  w_reject    = 1'b1;
               end
            end
         end
         XFER: begin
            if ((r_aw_done || w_aw_hs) && (!w_nonzero || (w_w_hs && w_last))) begin
               w_state_nxt = WAIT_B;
            end
         end
         WAIT_B: begin
            if (BVALID) begin
               w_b_hs      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------- request latch and status pulses ----------------
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_addr    <= '0;
         r_len     <= '0;
         r_aw_done <= 1'b0;
         r_gnt     <= 1'b0;
         r_done    <= 1'b0;
         r_resp    <= RESP_OKAY;
      end else begin
         if (w_accept) begin
            r_addr <= wt_word_addr_i;
            r_len  <= wt_len_i;
         end
         if (r_state != XFER) begin
            r_aw_done <= 1'b0;
         end else if (w_aw_hs) begin
            r_aw_done <= 1'b1;
         end
         r_gnt  <= w_accept || w_reject;
         r_done <= w_reject || w_b_hs;
         if (w_reject) begin
            r_resp <= RESP_SLVERR;
         end else if (w_b_hs) begin
            r_resp <= (BID != AXI4_ID_WIDTH'(WT_ID)) ? RESP_SLVERR : BRESP;
         end else begin
            r_resp <= RESP_OKAY;
         end
      end
   end

endmodule

// File: doc/axi_mem_burst_wt.md
AXI_MEM_BURST_WT -- requirements
Module: axi_mem_burst_wt

Interface
REQ-001 SHALL have parameter AXI4_ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter AXI4_DATA_WIDTH, default 32, data width; STRB width = AXI4_DATA_WIDTH/8.
REQ-003 SHALL have parameter AXI4_ID_WIDTH, default 16, AXI ID width.
REQ-004 SHALL have parameter AXI4_USER_WIDTH, default 10, AXI user width.
REQ-005 SHALL have parameter MAX_BURST, default 16, maximum beats per request (1..256); LW = $clog2(MAX_BURST+1).
REQ-006 SHALL have parameter WT_ID, default 0, constant AWID driven.
REQ-007 ACLK  input  1  clock; reset ARESETn, asynchronous, active-low; clock ACLK.
REQ-008 ARESETn  input  1  asynchronous active-low reset.
REQ-009 AW channel  output  AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT/AWREGION/AWUSER/AWQOS/AWVALID, input AWREADY  standard AXI4 widths.
REQ-010 W channel  output  WDATA/WSTRB/WLAST/WUSER/WVALID, input WREADY  standard AXI4 widths.
REQ-011 B channel  input  BID/BRESP/BUSER/BVALID, output BREADY  standard AXI4 widths.
REQ-012 wt_req_i  input  1  burst request; held with addr/len until wt_gnt_o.
REQ-013 wt_word_addr_i  input  AXI4_ADDR_WIDTH-2  start word address.
REQ-014 wt_len_i  input  LW  beat count, 1..MAX_BURST.
REQ-015 wt_gnt_o  output  1  one-cycle pulse: request accepted.
REQ-016 wt_dvalid_i / wt_data_i / wt_strb_i  input  1 / DATA / STRB  per-beat write data stream.
REQ-017 wt_dready_o  output  1  beat consumed when wt_dvalid_i & wt_dready_o.
REQ-018 wt_done_o / wt_resp_o  output  1 / 2  one-cycle completion pulse with BRESP.

Function
REQ-019 States SHALL be IDLE, XFER, WAIT_B; reset state IDLE.
REQ-020 IDLE: on wt_req_i with valid len, SHALL latch addr/len, pulse wt_gnt_o, go XFER; AWVALID asserts next cycle.
REQ-021 AWADDR = {addr,2'b00}, AWLEN = len-1, AWSIZE = 2, AWBURST = INCR (2'b01), other AW sideband and WUSER SHALL be 0.
REQ-022 XFER: AWVALID held until AWREADY; AW and W SHALL proceed independently (W beats may precede AW handshake).
REQ-023 W channel SHALL be a direct pass-through: WVALID = wt_dvalid_i & beats_left!=0, wt_dready_o = WREADY & beats_left!=0, WDATA/WSTRB from wt_data_i/wt_strb_i.
REQ-024 WLAST SHALL be 1 exactly on the beat where beats_left==1; beats_left decrements per W handshake.
REQ-025 XFER -> WAIT_B when AW handshake done and last beat accepted (same cycle allowed for both).
REQ-026 BREADY SHALL be 1 only in WAIT_B; on BVALID pulse wt_done_o, wt_resp_o=BRESP, return IDLE.
REQ-027 New request SHALL NOT be granted in the cycle wt_done_o pulses; earliest grant next cycle.
REQ-028 wt_len_i==0 or >MAX_BURST SHALL complete with no AXI traffic: wt_gnt_o and wt_done_o same cycle, wt_resp_o=SLVERR (2'b10).
REQ-029 BID mismatch with WT_ID SHALL be reported as wt_resp_o=SLVERR.

Reset
REQ-030 During ARESETn low: AWVALID, WVALID, WLAST, BREADY, wt_gnt_o, wt_dready_o, wt_done_o = 0; wt_resp_o = 0; counters 0; state IDLE.
REQ-031 Reset mid-burst SHALL abandon the transaction; no completion reported.

Configuration
REQ-032 Macro AXI_WT_4K_CHECK_EN defined: a burst whose byte range crosses a 4 KB boundary SHALL be rejected as in REQ-028 (SLVERR, no AXI traffic).
REQ-033 Macro undefined: no boundary check; such bursts issued as-is.

Structure
REQ-034 Package axi_wt_pkg SHALL hold state enum, AXI resp constants (OKAY/EXOKAY/SLVERR/DECERR), and BURST_INCR/SIZE_WORD constants.
REQ-035 Sub-module axi_wt_beat_cnt (loadable down-counter with last flag) SHALL implement beats_left/WLAST.

Verification
REQ-036 len=1, addr word 0x100, AWREADY/WREADY/BVALID immediate -> AWADDR=0x400, AWLEN=0, one beat WLAST=1, done resp=OKAY.
REQ-037 len=4, WREADY toggles 1/0, data before AWREADY (AWREADY delayed 5 cycles) -> 4 beats in order, WLAST on 4th, AWLEN=3.
REQ-038 len=0 and len=MAX_BURST+1 -> gnt+done same cycle, resp=10, AWVALID/WVALID never asserted.
REQ-039 BRESP=SLVERR, then BID!=WT_ID with OKAY -> wt_resp_o=10 both cases.
REQ-040 ARESETn low during 3rd of 8 beats -> all outputs 0 next edge, no wt_done_o; subsequent len=2 burst completes OKAY.
REQ-041 With AXI_WT_4K_CHECK_EN, word addr 0x3FE len=4 -> SLVERR, no AXI traffic; without macro -> issued, AWADDR=0xFF8.
